cr16_alu: RTL and testbench
===========================

Name: cr16_alu

Overview:
- 16-bit arithmetic/logic unit for the CR16 datapath.
- Computes a result from two operands and a 4-bit opcode, plus a 5-bit status word (carry, low, flag/overflow, zero, negative).
- Result and status are registered: one clock, synchronous active-high reset.
- Sits between the register-file read ports and the writeback/PSR logic.

Parameters:
- WIDTH, 16, operand/result width. Only 16 is supported.

Ports:
- I_CLK  in  1  clock; all state updates on the rising edge.
- I_RESET  in  1  synchronous, active-high reset.
- I_ENABLE  in  1  when high, result and status are captured on the rising edge.
- I_A  in  16  operand A.
- I_B  in  16  operand B.
- I_OPCODE  in  4  operation select.
- O_C  out  16  registered result.
- O_STATUS  out  5  registered flags: [0]=C carry, [1]=L low, [2]=F signed overflow, [3]=Z zero, [4]=N negative.

Behaviour:
- Reset: on a rising edge with I_RESET=1, O_C=0 and O_STATUS=0. Reset has priority over I_ENABLE.
- Latency: outputs reflect the inputs sampled at the last rising edge with I_ENABLE=1 (1 cycle). With I_ENABLE=0, outputs hold.
- Opcodes and results (R = next O_C, modulo 2^16):
  - 0 ADD: A+B, signed.
  - 1 ADDU: A+B, unsigned.
  - 2 ADDC: A+B+1, signed. The carry-in is constant 1.
  - 3 ADDCU: A+B+1, unsigned.
  - 4 MUL: low 16 bits of signed A*B.
  - 5 SUB: B-A. Note the operand order.
  - 6 NOT: ~A. I_B is ignored.
  - 7 AND, 8 OR, 9 XOR: bitwise.
  - 10 LSH: A << B.
  - 11 RSH: A >> B, logical.
  - 12 ALSH: A << B, identical to LSH.
  - 13 ARSH: A >> B, sign-extending.
  - 14, 15: R=0, status=0.
- Shift amount is the full unsigned 16-bit I_B. For B>=16:
  - LSH, RSH, ALSH give 0.
  - ARSH gives 0xFFFF if A[15]=1, else 0.
- Flag rules:
  - Z = (R==0) for opcodes 0-13.
  - ADD/ADDC: F = signed overflow (operands share a sign, R sign differs). N = R[15]. C=0, L=0.
  - ADDU/ADDCU: C = carry out of bit 15 of the 17-bit sum. F=0, N=0, L=0.
  - SUB: F = (A[15]!=B[15]) and (R[15]!=B[15]). N = R[15] XOR F, i.e. signed B<A. C=0, L=0.
  - MUL, NOT, AND, OR, XOR, all shifts: only Z is meaningful; C, L, F, N are 0.
  - L is reserved and is always 0 in this block.
- Wrap-around: all results truncate to 16 bits. ADD/SUB never saturate.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: opcode 4 performs signed multiply as above.
- Undefined: no multiplier is synthesized. Opcode 4 behaves as an unused opcode (R=0, status=0).

Test Plan:
- Reset: hold I_RESET=1 for one edge while ENABLE=1, ADD A=5 B=5 → O_C=0x0000, O_STATUS=5'b00000. Then release; ENABLE=0 with new operands → outputs stay 0.
- ADD A=0x7C00 B=0x0400 → O_C=0x8000, O_STATUS=5'b10100 (N, F). ADDC A=0x0005 B=0xFFFD → O_C=0x0003, O_STATUS=0.
- ADDU A=0xFC00 B=0x0400 → O_C=0x0000, O_STATUS=5'b01001 (Z, C). ADDCU A=0x8000 B=0x7FFF → O_C=0x0000, O_STATUS=5'b01001.
- SUB A=0x0400 B=0x0000 → O_C=0xFC00, O_STATUS=5'b10000. SUB A=0x8000 B=0x0000 → O_C=0x8000, O_STATUS=5'b00100. SUB A=B=0x1234 → O_C=0, O_STATUS=5'b01000.
- Shifts:
  - LSH A=0x00F0 B=4 → 0x0F00.
  - RSH A=0x8000 B=4 → 0x0800.
  - ARSH A=0x8000 B=4 → 0xF800.
  - ARSH A=0x8000 B=0x0400 → 0xFFFF.
  - LSH A=0xFFFF B=16 → 0x0000, Z=1.
- Logic and multiply (ALU_MUL_EN defined):
  - MUL A=0xFFFE B=0x0003 → 0xFFFA.
  - AND A=0xF0F0 B=0xFF00 → 0xF000.
  - XOR A=B=0xAAAA → 0x0000, Z=1.
  - NOT A=0x00FF → 0xFF00.
  - Opcode 15 → O_C=0, O_STATUS=0.

Source files
------------

// File: rtl/cr16_alu.sv
// CR16 16-bit ALU: registered result and 5-bit status {N, Z, F, L, C}.
// Optional macro ALU_MUL_EN adds the signed multiplier on opcode 4.
module cr16_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             I_CLK,
  input  logic             I_RESET,
  input  logic             I_ENABLE,
  input  logic [WIDTH-1:0] I_A,
  input  logic [WIDTH-1:0] I_B,
  input  logic [3:0]       I_OPCODE,
  output logic [WIDTH-1:0] O_C,
  output logic [4:0]       O_STATUS
);

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpAddu  = 4'd1,
    OpAddc  = 4'd2,
    OpAddcu = 4'd3,
    OpMul   = 4'd4,
    OpSub   = 4'd5,
    OpNot   = 4'd6,
    OpAnd   = 4'd7,
    OpOr    = 4'd8,
    OpXor   = 4'd9,
    OpLsh   = 4'd10,
    OpRsh   = 4'd11,
    OpAlsh  = 4'd12,
    OpArsh  = 4'd13,
    OpRsv14 = 4'd14,
    OpRsv15 = 4'd15
  } op_e;

  localparam int unsigned ShW = $clog2(WIDTH);
  localparam int unsigned Msb = WIDTH - 1;

  op_e op;
  assign op = op_e'(I_OPCODE);

  // Shared adder; the carry-in variants add a constant 1.
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  assign cin  = (op == OpAddc) || (op == OpAddcu);
  assign sum  = {1'b0, I_A} + {1'b0, I_B} + {{WIDTH{1'b0}}, cin};
  assign diff = I_B - I_A;

  // Any set bit above the shift field means the whole operand is shifted out.
  logic [ShW-1:0]   shamt;
  logic             sh_big;
  logic [WIDTH-1:0] lsh_res;
  logic [WIDTH-1:0] rsh_res;
  logic [WIDTH-1:0] arsh_res;
  assign shamt    = I_B[ShW-1:0];
  assign sh_big   = |I_B[WIDTH-1:ShW];
  assign lsh_res  = sh_big ? '0 : (I_A << shamt);
  assign rsh_res  = sh_big ? '0 : (I_A >> shamt);
  assign arsh_res = sh_big ? {WIDTH{I_A[Msb]}} : $unsigned($signed(I_A) >>> shamt);

`ifdef ALU_MUL_EN
  // Low half of a product is identical for signed and unsigned operands.
  logic [WIDTH-1:0] mul_res;
  assign mul_res = I_A * I_B;
`endif

  logic [WIDTH-1:0] res_d;
  logic [4:0]       status_d;
  logic             valid_op;
  logic             flag_n;
  logic             flag_z;
  logic             flag_f;
  logic             flag_c;

  always_comb begin
    res_d    = '0;
    valid_op = 1'b1;
    flag_n   = 1'b0;
    flag_f   = 1'b0;
    flag_c   = 1'b0;
    unique case (op)
      OpAdd, OpAddc: begin
        res_d  = sum[WIDTH-1:0];
        flag_f = (I_A[Msb] == I_B[Msb]) && (res_d[Msb] != I_A[Msb]);
        flag_n = res_d[Msb];
      end
      OpAddu, OpAddcu: begin
        res_d  = sum[WIDTH-1:0];
        flag_c = sum[WIDTH];
      end
      OpMul: begin
`ifdef ALU_MUL_EN
        res_d    = mul_res;
`else
        valid_op = 1'b0;
`endif
      end
      OpSub: begin
        res_d  = diff;
        flag_f = (I_A[Msb] != I_B[Msb]) && (diff[Msb] != I_B[Msb]);
        // N reports signed B < A, corrected for overflow.
        flag_n = diff[Msb] ^ flag_f;
      end
      OpNot:          res_d = ~I_A;
      OpAnd:          res_d = I_A & I_B;
      OpOr:           res_d = I_A | I_B;
      OpXor:          res_d = I_A ^ I_B;
      OpLsh, OpAlsh:  res_d = lsh_res;
      OpRsh:          res_d = rsh_res;
      OpArsh:         res_d = arsh_res;
      OpRsv14,
      OpRsv15:        valid_op = 1'b0;
      default:        valid_op = 1'b0;
    endcase
    flag_z   = valid_op && (res_d == '0);
    status_d = {flag_n, flag_z, flag_f, 1'b0, flag_c};
  end

  logic [WIDTH-1:0] c_q;
  logic [4:0]       status_q;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      c_q      <= '0;
      status_q <= '0;
    end else if (I_ENABLE) begin
      c_q      <= res_d;
      status_q <= status_d;
    end
  end

  assign O_C      = c_q;
  assign O_STATUS = status_q;

endmodule

// File: tb/tb_cr16_alu.sv
// Directed self-checking bench for cr16_alu; each task owns its vectors and checks.
module tb_cr16_alu;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  op;
  logic [15:0] c_o;
  logic [4:0]  st_o;

  int checks = 0;
  int errors = 0;

  cr16_alu #(.WIDTH(16)) dut (
    .I_CLK   (clk),
    .I_RESET (rst),
    .I_ENABLE(en),
    .I_A     (a),
    .I_B     (b),
    .I_OPCODE(op),
    .O_C     (c_o),
    .O_STATUS(st_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs away from the edge, then sample 1 time unit after it.
  task automatic drive(input logic e, input logic [3:0] o, input logic [15:0] av,
                       input logic [15:0] bv);
    @(negedge clk);
    en = e;
    op = o;
    a  = av;
    b  = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'd0, 16'd5, 16'd5);
    checks++;
    if (c_o !== 16'h0000 || st_o !== 5'b00000) begin
      errors++;
      $display("FAIL reset: got c=%h st=%b, want c=0000 st=00000", c_o, st_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'd0, 16'h7C00, 16'h0400);
      checks++;
      if (c_o !== 16'h0000 || st_o !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got c=%h st=%b, want c=0000 st=00000", i, c_o, st_o);
      end
    end
  endtask

  task automatic test_add();
    logic [3:0]  ov [7];
    logic [15:0] av [7];
    logic [15:0] bv [7];
    logic [15:0] ec [7];
    logic [4:0]  es [7];
    ov = '{4'd0,     4'd2,     4'd1,     4'd3,     4'd0,     4'd1,     4'd3};
    av = '{16'h7C00, 16'h0005, 16'hFC00, 16'h8000, 16'h8000, 16'h0001, 16'hFFFF};
    bv = '{16'h0400, 16'hFFFD, 16'h0400, 16'h7FFF, 16'h8000, 16'h0002, 16'hFFFF};
    ec = '{16'h8000, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'hFFFF};
    es = '{5'b10100, 5'b00000, 5'b01001, 5'b01001, 5'b01100, 5'b00000, 5'b00001};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ov[i], av[i], bv[i]);
      checks++;
      if (c_o !== ec[i] || st_o !== es[i]) begin
        errors++;
        $display("FAIL add[%0d] op=%0d a=%h b=%h: got c=%h st=%b, want c=%h st=%b",
                 i, ov[i], av[i], bv[i], c_o, st_o, ec[i], es[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [15:0] av [4];
    logic [15:0] bv [4];
    logic [15:0] ec [4];
    logic [4:0]  es [4];
    av = '{16'h0400, 16'h8000, 16'h1234, 16'h0001};
    bv = '{16'h0000, 16'h0000, 16'h1234, 16'h8000};
    ec = '{16'hFC00, 16'h8000, 16'h0000, 16'h7FFF};
    es = '{5'b10000, 5'b00100, 5'b01000, 5'b10100};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd5, av[i], bv[i]);
      checks++;
      if (c_o !== ec[i] || st_o !== es[i]) begin
        errors++;
        $display("FAIL sub[%0d] a=%h b=%h: got c=%h st=%b, want c=%h st=%b",
                 i, av[i], bv[i], c_o, st_o, ec[i], es[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [3:0]  ov [8];
    logic [15:0] av [8];
    logic [15:0] bv [8];
    logic [15:0] ec [8];
    logic [4:0]  es [8];
    ov = '{4'd10,    4'd11,    4'd13,    4'd13,    4'd10,    4'd11,    4'd13,    4'd12};
    av = '{16'h00F0, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0001};
    bv = '{16'h0004, 16'h0004, 16'h0004, 16'h0400, 16'h0010, 16'h0010, 16'h0100, 16'h000F};
    ec = '{16'h0F00, 16'h0800, 16'hF800, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
    es = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b01000, 5'b01000, 5'b00000};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, ov[i], av[i], bv[i]);
      checks++;
      if (c_o !== ec[i] || st_o !== es[i]) begin
        errors++;
        $display("FAIL shift[%0d] op=%0d a=%h b=%h: got c=%h st=%b, want c=%h st=%b",
                 i, ov[i], av[i], bv[i], c_o, st_o, ec[i], es[i]);
      end
    end
  endtask

  task automatic test_logic_mul();
    logic [3:0]  ov [7];
    logic [15:0] av [7];
    logic [15:0] bv [7];
    logic [15:0] ec [7];
    logic [4:0]  es [7];
    ov = '{4'd4,     4'd7,     4'd9,     4'd6,     4'd8,     4'd15,    4'd14};
    av = '{16'hFFFE, 16'hF0F0, 16'hAAAA, 16'h00FF, 16'h0F00, 16'hFFFF, 16'h0000};
    bv = '{16'h0003, 16'hFF00, 16'hAAAA, 16'h1234, 16'h00F0, 16'hFFFF, 16'h0000};
`ifdef ALU_MUL_EN
    ec = '{16'hFFFA, 16'hF000, 16'h0000, 16'hFF00, 16'h0FF0, 16'h0000, 16'h0000};
`else
    ec = '{16'h0000, 16'hF000, 16'h0000, 16'hFF00, 16'h0FF0, 16'h0000, 16'h0000};
`endif
    es = '{5'b00000, 5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ov[i], av[i], bv[i]);
      checks++;
      if (c_o !== ec[i] || st_o !== es[i]) begin
        errors++;
        $display("FAIL logic[%0d] op=%0d a=%h b=%h: got c=%h st=%b, want c=%h st=%b",
                 i, ov[i], av[i], bv[i], c_o, st_o, ec[i], es[i]);
      end
    end
  endtask

  task automatic test_enable_hold();
    drive(1'b1, 4'd0, 16'h7C00, 16'h0400);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd5, 16'h1234, 16'h1234);
      checks++;
      if (c_o !== 16'h8000 || st_o !== 5'b10100) begin
        errors++;
        $display("FAIL hold[%0d]: got c=%h st=%b, want c=8000 st=10100", i, c_o, st_o);
      end
    end
    // Reset wins even with enable low.
    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0001, 16'h0001);
    rst = 1'b0;
    checks++;
    if (c_o !== 16'h0000 || st_o !== 5'b00000) begin
      errors++;
      $display("FAIL reset_no_en: got c=%h st=%b, want c=0000 st=00000", c_o, st_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    op  = 4'd0;
    a   = 16'h0000;
    b   = 16'h0000;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_logic_mul();
    test_enable_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
